// File: rtl/load_return_unit.sv
// Load-data return path: captures loads at issue, selects DMEM/BIOS/MMIO on return, extracts and extends lanes.
// Also owns the performance counters and the RX-FIFO pop. Define LOAD_RETURN_OUT_REG_EN for a registered output stage.
module load_return_unit #(
    parameter int          DATA_W       = 32,
    parameter int          N_CNT        = 4,
    parameter logic [31:0] CNT_BASE     = 32'h8000_0010,
    parameter logic [31:0] CNT_RST_ADDR = 32'h8000_0018,
    localparam int         NB           = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    input  logic [NB-1:0]     req_mask,
    input  logic              req_sign,
    input  logic [DATA_W-1:0] dmem_dout,
    input  logic [DATA_W-1:0] bios_dout,
    input  logic              rx_fifo_empty,
    input  logic [7:0]        rx_fifo_out,
    input  logic              tx_ready,
    output logic              rx_fifo_rd,
    input  logic [N_CNT-1:0]  cnt_inc,
    input  logic              wr_valid,
    input  logic [31:0]       wr_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int          LOG_NB         = $clog2(NB);
    localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;

    logic [31:0]       cnt_val [N_CNT];
    logic              cnt_clr;
    logic [DATA_W-1:0] mmio_snap;

    logic              cap_valid_reg;
    logic [3:0]        cap_region_reg;
    logic [NB-1:0]     cap_mask_reg;
    logic              cap_sign_reg;
    logic [DATA_W-1:0] cap_mmio_reg;

    logic [DATA_W-1:0] src_word;
    logic              region_err;
    logic              lane_ok;
    logic [3:0]        lane_lo;
    logic [3:0]        lane_sz;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] field_mask;
    logic              sign_bit;
    logic [DATA_W-1:0] ext_data;

    logic              rsp_valid_c;
    logic [DATA_W-1:0] rsp_data_c;
    logic              rsp_err_c;

    assign cnt_clr    = wr_valid && (wr_addr == CNT_RST_ADDR);
    assign rx_fifo_rd = req_valid && (req_addr == UART_RX_ADDR) && !rx_fifo_empty && !reset;

    // Clear has priority over a same-cycle increment.
    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : gen_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge clock) begin
                if (reset || cnt_clr) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    always_comb begin
        mmio_snap = '0;
        if (req_addr == UART_CTRL_ADDR) begin
            mmio_snap = DATA_W'({~rx_fifo_empty, tx_ready});
        end else if (req_addr == UART_RX_ADDR) begin
            mmio_snap = DATA_W'(rx_fifo_out);
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if (req_addr == CNT_BASE + 32'(4 * i)) begin
                    mmio_snap = DATA_W'(cnt_val[i]);
                end
            end
        end
    end

    // The MMIO value is frozen at issue, so only the region nibble of the address is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_valid_reg  <= 1'b0;
            cap_region_reg <= '0;
            cap_mask_reg   <= '0;
            cap_sign_reg   <= 1'b0;
            cap_mmio_reg   <= '0;
        end else begin
            cap_valid_reg <= req_valid;
            if (req_valid) begin
                cap_region_reg <= req_addr[31:28];
                cap_mask_reg   <= req_mask;
                cap_sign_reg   <= req_sign;
                cap_mmio_reg   <= mmio_snap;
            end
        end
    end

    always_comb begin
        src_word   = '0;
        region_err = 1'b0;
        case (cap_region_reg)
            4'h1, 4'h3: src_word = dmem_dout;
            4'h4:       src_word = bios_dout;
            4'h8:       src_word = cap_mmio_reg;
            default:    region_err = 1'b1;
        endcase
    end

    // Accept only masks that are a naturally aligned power-of-two run of lanes.
    always_comb begin
        lane_ok = 1'b0;
        lane_lo = '0;
        lane_sz = 4'd1;
        for (int k = 0; k <= LOG_NB; k++) begin
            for (int l = 0; l < NB; l += (1 << k)) begin
                if (cap_mask_reg == NB'(((1 << (1 << k)) - 1) << l)) begin
                    lane_ok = 1'b1;
                    lane_lo = 4'(l);
                    lane_sz = 4'(1 << k);
                end
            end
        end
    end

    always_comb begin
        shifted    = src_word >> {lane_lo, 3'b000};
        field_mask = (lane_sz == 4'(NB)) ? {DATA_W{1'b1}}
                                         : ((DATA_W'(1) << {lane_sz, 3'b000}) - DATA_W'(1));
        sign_bit   = |(shifted & field_mask & ~(field_mask >> 1));
        ext_data   = shifted & field_mask;
        if (cap_sign_reg && sign_bit) begin
            ext_data = ext_data | ~field_mask;
        end
    end

    always_comb begin
        rsp_valid_c = cap_valid_reg;
        rsp_err_c   = cap_valid_reg && (region_err || !lane_ok);
        rsp_data_c  = (cap_valid_reg && !region_err && lane_ok) ? ext_data : '0;
    end

`ifdef LOAD_RETURN_OUT_REG_EN
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_err_reg   <= 1'b0;
        end else begin
            out_valid_reg <= rsp_valid_c;
            out_data_reg  <= rsp_data_c;
            out_err_reg   <= rsp_err_c;
        end
    end

    assign rsp_valid = out_valid_reg;
    assign rsp_data  = out_data_reg;
    assign rsp_err   = out_err_reg;
`else
    assign rsp_valid = rsp_valid_c;
    assign rsp_data  = rsp_data_c;
    assign rsp_err   = rsp_err_c;
`endif

endmodule
